// File: rtl/argmax_16_pkg.sv
// Shared layer package: default vector length, data width and the signed data word.
package argmax_16_pkg;
    localparam int ARGMAX_M    = 16;
    localparam int ARGMAX_W    = 16;
    localparam int ARGMAX_IDXW = $clog2(ARGMAX_M);

    typedef logic signed [ARGMAX_W-1:0] data_t;
endpackage

// File: rtl/argmax_16.sv
// Streaming argmax: folds M signed elements per vector into (index, value) of the maximum,
// with a one-deep result register that lets the next vector collect while a result is pending.
module argmax_16
    import argmax_16_pkg::*;
#(
    parameter int M = ARGMAX_M,
    parameter int W = ARGMAX_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [W-1:0]         data_in,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(M)-1:0]        idx_out,
    output logic signed [W-1:0]         max_out
);
    localparam int IDXW = $clog2(M);

    logic [IDXW-1:0]     cnt;
    logic [IDXW-1:0]     run_idx;
    logic signed [W-1:0] run_max;

    logic                last;
    logic                accept;
    logic                take_new;
    logic [IDXW-1:0]     nxt_idx;
    logic signed [W-1:0] nxt_max;

    // Only the last element can stall, and only while the previous result is still unclaimed.
    always_comb begin
        last     = (cnt == IDXW'(M - 1));
        s_ready  = !(last && m_valid && !m_ready);
        accept   = s_valid && s_ready;
        take_new = (cnt == '0) || (data_in > run_max);
        nxt_max  = take_new ? data_in : run_max;
        nxt_idx  = take_new ? cnt : run_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            run_idx <= '0;
            run_max <= '0;
            m_valid <= 1'b0;
            idx_out <= '0;
            max_out <= '0;
        end else begin
            if (accept) begin
                cnt     <= last ? '0 : cnt + 1'b1;
                run_idx <= nxt_idx;
                run_max <= nxt_max;
            end
            // A new result overrides the handshake clear, so back-to-back results have no bubble.
            if (accept && last) begin
                m_valid <= 1'b1;
                idx_out <= nxt_idx;
                max_out <= nxt_max;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
